aes_ctr_unpacker: RTL and testbench

- Downstream stage of aes_ctr. It consumes the 128-bit keystream-XORed blocks on dout_o/dout_valid_o, which is valid-only with no backpressure.
- It buffers them in a small FIFO and serialises each block into four 32-bit words on a valid/ready stream for a word-wide sink (bus master, UART/DMA bridge).
- almost_full_o is provided so the feeder of aes_ctr can gate din_valid_i and avoid loss.

---
 rtl/aes_ctr_unpacker.sv | 103 ++++++++++
 tb/tb_aes_ctr_unpacker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_unpacker.sv
// Buffers 128-bit blocks from aes_ctr and serialises each into four MSB-first 32-bit words.
// Latency: word 0 valid 1 cycle after the block strobe; blocks arriving with no space are dropped (sticky overflow_o).
module aes_ctr_unpacker #(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [127:0]                 blk_i,
  input  logic                         blk_valid_i,
  output logic [31:0]                  word_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic                         word_first_o,
  output logic                         word_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {EMPTY, SERVE} state_t;

  state_t          state_q;
  logic [127:0]    mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      idx_q;
  logic            af_q, ovf_q;

  logic [127:0]    head;
  logic            hs, pop, space, wr;

  assign head  = mem_q[rptr_q];
  assign hs    = (state_q == SERVE) && word_ready_i;
  assign pop   = hs && (idx_q == 2'd3);
  // A final-word pop frees its slot in the same cycle, so a full FIFO can still take a block.
  assign space = (count_q < CW'(DEPTH)) || pop;
  assign wr    = blk_valid_i && space;

  always_comb begin
    count_d = count_q;
    if (wr && !pop)
      count_d = count_q + CW'(1);
    else if (!wr && pop)
      count_d = count_q - CW'(1);
  end

  always_comb begin
    word_o = '0;
    if (state_q == SERVE) begin
      case (idx_q)
        2'd0:    word_o = head[127:96];
        2'd1:    word_o = head[95:64];
        2'd2:    word_o = head[63:32];
        default: word_o = head[31:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wptr_q] <= blk_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr)
        wptr_q <= wptr_q + PW'(1);
      if (hs)
        idx_q <= idx_q + 2'd1;
      if (pop)
        rptr_q <= rptr_q + PW'(1);
      if (blk_valid_i && !space)
        ovf_q <= 1'b1;
      count_q <= count_d;
      af_q    <= (int'(count_d) >= (DEPTH - AF_MARGIN));
      case (state_q)
        EMPTY:   if (count_d != '0) state_q <= SERVE;
        SERVE:   if (count_d == '0) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign word_valid_o  = (state_q == SERVE);
  assign word_first_o  = (state_q == SERVE) && (idx_q == 2'd0);
  assign word_last_o   = (state_q == SERVE) && (idx_q == 2'd3);
  assign count_o       = count_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_aes_ctr_unpacker.sv
// Bench for aes_ctr_unpacker: table-driven basic block, hand sequences for corner cases, scoreboarded random stream.
module tb_aes_ctr_unpacker;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] blk_i = '0;
  logic         blk_valid_i = 1'b0;
  logic [31:0]  word_o;
  logic         word_valid_o;
  logic         word_ready_i = 1'b0;
  logic         word_first_o;
  logic         word_last_o;
  logic [2:0]   count_o;
  logic         almost_full_o;
  logic         overflow_o;

  aes_ctr_unpacker #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n), .blk_i(blk_i), .blk_valid_i(blk_valid_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_first_o(word_first_o), .word_last_o(word_last_o), .count_o(count_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        first;
    logic        last;
  } exp_t;

  typedef struct {
    logic        vld;
    logic        rdy;
    logic        ev;
    logic [31:0] ew;
    logic        ef;
    logic        el;
    logic [2:0]  ec;
  } vec_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  logic        mover = 1'b0;
  logic        held_vld = 1'b0;
  logic [31:0] held_w = '0;
  logic        held_f = 1'b0;
  logic        held_l = 1'b0;
  int          hs_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_blk(input logic [127:0] b);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.w     = b[127 - 32*i -: 32];
      e.first = (i == 0);
      e.last  = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    mcount   = 0;
    mover    = 1'b0;
    held_vld = 1'b0;
  endtask

  // One clock: called #1 after a rising edge, drives inputs, checks, returns #1 after the next edge.
  task automatic cyc(input logic vld, input logic [127:0] blk, input logic rdy);
    logic pop_m, space;
    exp_t e;
    blk_valid_i  = vld;
    blk_i        = blk;
    word_ready_i = rdy;
    pop_m = 1'b0;
    if (held_vld) begin
      chk("stall_valid", word_valid_o, 1'b1);
      chk("stall_word", word_o, held_w);
      chk("stall_first", word_first_o, held_f);
      chk("stall_last", word_last_o, held_l);
    end
    if (!word_valid_o)
      chk("idle_word_zero", word_o, 32'h0);
    if (word_valid_o && rdy) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        chk("spurious_word", word_valid_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("word", word_o, e.w);
        chk("first", word_first_o, e.first);
        chk("last", word_last_o, e.last);
        pop_m = e.last;
      end
    end
    held_vld = word_valid_o && !rdy;
    held_w   = word_o;
    held_f   = word_first_o;
    held_l   = word_last_o;
    space = (mcount < DEPTH) || pop_m;
    if (vld && space) push_blk(blk);
    else if (vld) mover = 1'b1;
    mcount = mcount + ((vld && space) ? 1 : 0) - (pop_m ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", count_o, mcount);
    chk("overflow", overflow_o, mover);
    chk("almost_full", almost_full_o, (mcount >= DEPTH - AF_MARGIN));
    chk("valid", word_valid_o, (mcount != 0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, word_valid_o, 1'b0);
    chk({tag, "_word"}, word_o, 32'h0);
    chk({tag, "_first"}, word_first_o, 1'b0);
    chk({tag, "_last"}, word_last_o, 1'b0);
    chk({tag, "_count"}, count_o, 3'd0);
    chk({tag, "_af"}, almost_full_o, 1'b0);
    chk({tag, "_ovf"}, overflow_o, 1'b0);
  endtask

  initial begin
    vec_t         tbl[5];
    logic [127:0] blk;
    logic         pat[7];
    logic [127:0] b;
    logic         v;
    int           hs0, sent, n;

    blk = 128'h00112233_44556677_8899aabb_ccddeeff;
    tbl[0] = '{vld: 1'b1, rdy: 1'b1, ev: 1'b1, ew: 32'h00112233, ef: 1'b1, el: 1'b0, ec: 3'd1};
    tbl[1] = '{vld: 1'b0, rdy: 1'b1, ev: 1'b1, ew: 32'h44556677, ef: 1'b0, el: 1'b0, ec: 3'd1};
    tbl[2] = '{vld: 1'b0, rdy: 1'b1, ev: 1'b1, ew: 32'h8899aabb, ef: 1'b0, el: 1'b0, ec: 3'd1};
    tbl[3] = '{vld: 1'b0, rdy: 1'b1, ev: 1'b1, ew: 32'hccddeeff, ef: 1'b0, el: 1'b1, ec: 3'd1};
    tbl[4] = '{vld: 1'b0, rdy: 1'b1, ev: 1'b0, ew: 32'h0,        ef: 1'b0, el: 1'b0, ec: 3'd0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    #1;
    check_all_zero("reset");
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");

    // Basic block, ready held high
    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].vld, tbl[i].vld ? blk : 128'h0, tbl[i].rdy);
      chk("tbl_valid", word_valid_o, tbl[i].ev);
      chk("tbl_word", word_o, tbl[i].ew);
      chk("tbl_first", word_first_o, tbl[i].ef);
      chk("tbl_last", word_last_o, tbl[i].el);
      chk("tbl_count", count_o, tbl[i].ec);
    end

    // Backpressure with toggling ready
    hs0 = hs_total;
    cyc(1'b1, blk, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 128'h0, pat[i]);
    cyc(1'b0, 128'h0, 1'b1);
    chk("bp_handshakes", hs_total - hs0, 4);
    chk("bp_drained", exp_q.size(), 0);

    // Fill and overflow with the sink stalled
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, {4{32'hb0000000 + i}}, 1'b0);
      if (i == 1) chk("fill_af_at2", almost_full_o, 1'b0);
      if (i == 2) chk("fill_af_at3", almost_full_o, 1'b1);
    end
    chk("fill_count", count_o, 3'd4);
    chk("fill_ovf", overflow_o, 1'b1);
    for (int i = 0; i < 18; i++) cyc(1'b0, 128'h0, 1'b1);
    chk("fill_drained", exp_q.size(), 0);
    chk("fill_ovf_sticky", overflow_o, 1'b1);

    // Reset mid-block with two blocks queued
    cyc(1'b1, 128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3, 1'b0);
    cyc(1'b1, 128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3, 1'b0);
    cyc(1'b0, 128'h0, 1'b1);
    cyc(1'b0, 128'h0, 1'b1);
    word_ready_i = 1'b0;
    blk_valid_i  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    clear_model();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 128'h0, 1'b1);
    cyc(1'b1, 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 128'h0, 1'b1);
    chk("rst_new_drained", exp_q.size(), 0);

    // Full FIFO, new block in the same cycle as the head's final word
    for (int i = 0; i < 4; i++) cyc(1'b1, {4{32'hf0000000 + i}}, 1'b0);
    chk("full_count", count_o, 3'd4);
    for (int i = 0; i < 3; i++) cyc(1'b0, 128'h0, 1'b1);
    cyc(1'b1, 128'hf4f4f4f4_f5f5f5f5_f6f6f6f6_f7f7f7f7, 1'b1);
    chk("full_pop_count", count_o, 3'd4);
    chk("full_pop_ovf", overflow_o, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 128'h0, 1'b1);
    chk("full_pop_drained", exp_q.size(), 0);

    // Random stream gated by almost_full, random sink ready
    hs0  = hs_total;
    sent = 0;
    n    = 0;
    while ((sent < 100 || exp_q.size() != 0) && n < 20000) begin
      v = (sent < 100) && !almost_full_o && 1'($urandom_range(0, 1));
      b = {$urandom, $urandom, $urandom, $urandom};
      cyc(v, b, 1'($urandom_range(0, 1)));
      if (v) sent++;
      n++;
    end
    chk("e2e_timeout", (n < 20000), 1'b1);
    chk("e2e_words", hs_total - hs0, 400);
    chk("e2e_ovf", overflow_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
